sram22_sram_pipe_masked: RTL and testbench

SRAM22_SRAM_PIPE_MASKED -- requirements
Module: sram22_sram_pipe_masked

---
 rtl/sram22_sram_pipe_masked_if.sv | 26 ++
 rtl/sram22_sram_pipe_masked.sv | 138 +++++++++++++
 tb/tb_sram22_sram_pipe_masked.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/sram22_sram_pipe_masked_if.sv
// Request/response bundle for the masked-write pipelined SRAM.
interface sram22_sram_pipe_masked_if #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WMASK_WIDTH = 4
);
  logic                   req_valid;
  logic                   req_ready;
  logic                   we;
  logic [WMASK_WIDTH-1:0] wmask;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [DATA_WIDTH-1:0]  din;
  logic [DATA_WIDTH-1:0]  dout;
  logic                   dout_valid;
  logic                   busy;

  modport master (
    output req_valid, we, wmask, addr, din,
    input  req_ready, dout, dout_valid, busy
  );

  modport slave (
    input  req_valid, we, wmask, addr, din,
    output req_ready, dout, dout_valid, busy
  );
endinterface

// File: rtl/sram22_sram_pipe_masked.sv
// Single-port SRAM with per-lane write mask and 1- or 2-cycle registered read.
// Define SRAM22_CLEAR_ON_RESET_EN to zero the whole array with a sweep after every reset.
module sram22_sram_pipe_masked #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned WMASK_WIDTH  = 4,
  parameter int unsigned READ_LATENCY = 1
) (
  input logic                      clk,
  input logic                      rstb,
  sram22_sram_pipe_masked_if.slave bus
);
  localparam int unsigned RAM_DEPTH  = 1 << ADDR_WIDTH;
  localparam int unsigned LANE_WIDTH = DATA_WIDTH / WMASK_WIDTH;

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("sram22_sram_pipe_masked: READ_LATENCY must be 1 or 2");
  end
  if ((DATA_WIDTH % WMASK_WIDTH) != 0) begin : g_bad_mask
    $error("sram22_sram_pipe_masked: DATA_WIDTH must be a multiple of WMASK_WIDTH");
  end

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  logic                  clearing;
  logic [ADDR_WIDTH-1:0] clear_addr;
  logic                  accept;
  logic                  wr_accept;
  logic                  rd_accept;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  dout_valid_q;

`ifdef SRAM22_CLEAR_ON_RESET_EN
  localparam logic [0:0]            ST_CLEAR   = 1'b0;
  localparam logic [0:0]            ST_IDLE    = 1'b1;
  localparam logic [ADDR_WIDTH:0]   SWEEP_LAST = (ADDR_WIDTH + 1)'(RAM_DEPTH - 1);

  logic [0:0]          state;
  logic [0:0]          state_next;
  logic [ADDR_WIDTH:0] sweep_cnt;
  logic [ADDR_WIDTH:0] sweep_cnt_next;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state     <= ST_CLEAR;
      sweep_cnt <= '0;
    end else begin
      state     <= state_next;
      sweep_cnt <= sweep_cnt_next;
    end
  end

  // Counter is one bit wider than the address so the last word is written before exit.
  always_comb begin
    state_next     = state;
    sweep_cnt_next = sweep_cnt;
    clearing       = 1'b0;
    case (state)
      ST_CLEAR: begin
        clearing       = 1'b1;
        sweep_cnt_next = sweep_cnt + (ADDR_WIDTH + 1)'(1);
        if (sweep_cnt == SWEEP_LAST) begin
          state_next = ST_IDLE;
        end
      end
      ST_IDLE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_CLEAR;
      end
    endcase
  end

  assign clear_addr = sweep_cnt[ADDR_WIDTH-1:0];
`else
  assign clearing   = 1'b0;
  assign clear_addr = '0;
`endif

  assign bus.busy      = clearing;
  assign bus.req_ready = ~clearing;

  assign accept    = bus.req_valid & ~clearing;
  assign wr_accept = accept & bus.we;
  assign rd_accept = accept & ~bus.we;

  // Array is never touched by reset; only the sweep or accepted writes change it.
  always_ff @(posedge clk) begin
    if (clearing) begin
      mem[clear_addr] <= '0;
    end else if (wr_accept) begin
      for (int unsigned i = 0; i < WMASK_WIDTH; i++) begin
        if (bus.wmask[i]) begin
          mem[bus.addr][i*LANE_WIDTH +: LANE_WIDTH] <= bus.din[i*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;

    always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
        rd_data      <= '0;
        rd_valid     <= 1'b0;
        dout_q       <= '0;
        dout_valid_q <= 1'b0;
      end else begin
        rd_valid     <= rd_accept;
        dout_valid_q <= rd_valid;
        if (rd_accept) begin
          rd_data <= mem[bus.addr];
        end
        if (rd_valid) begin
          dout_q <= rd_data;
        end
      end
    end
  end else begin : g_lat1
    always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
        dout_q       <= '0;
        dout_valid_q <= 1'b0;
      end else begin
        dout_valid_q <= rd_accept;
        if (rd_accept) begin
          dout_q <= mem[bus.addr];
        end
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
endmodule

// File: tb/tb_sram22_sram_pipe_masked.sv
// Bench for sram22_sram_pipe_masked: latency-1 and latency-2 instances share one memory model.
module tb_sram22_sram_pipe_masked;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 4;
  localparam int unsigned MW    = 4;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned LW    = DW / MW;
`ifdef SRAM22_CLEAR_ON_RESET_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstb;
  always #5 clk = ~clk;

  sram22_sram_pipe_masked_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW)) bus1 ();
  sram22_sram_pipe_masked_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW)) bus2 ();

  sram22_sram_pipe_masked #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW), .READ_LATENCY(1))
    u_dut1 (.clk(clk), .rstb(rstb), .bus(bus1));
  sram22_sram_pipe_masked #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW), .READ_LATENCY(2))
    u_dut2 (.clk(clk), .rstb(rstb), .bus(bus2));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: word array, remaining clear cycles, and reads queued by due cycle.
  typedef struct { int due; logic [DW-1:0] data; } rd_t;
  logic [DW-1:0] mem_m [DEPTH];
  rd_t           q1[$];
  rd_t           q2[$];
  int            cyc        = 0;
  int            clear_left = CLR_EN ? int'(DEPTH) : 0;
  logic          exp_v1 = 1'b0, exp_v2 = 1'b0;
  logic [DW-1:0] exp_d1 = '0, exp_d2 = '0;

  initial for (int i = 0; i < int'(DEPTH); i++) mem_m[i] = '0;

  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      q1.delete();
      q2.delete();
      exp_v1     = 1'b0;
      exp_v2     = 1'b0;
      exp_d1     = '0;
      exp_d2     = '0;
      clear_left = CLR_EN ? int'(DEPTH) : 0;
    end else begin
      cyc++;
      if (clear_left > 0) begin
        mem_m[int'(DEPTH) - clear_left] = '0;
        clear_left--;
      end else if (bus1.req_valid) begin
        if (bus1.we) begin
          for (int i = 0; i < int'(MW); i++)
            if (bus1.wmask[i]) mem_m[bus1.addr][i*LW +: LW] = bus1.din[i*LW +: LW];
        end else begin
          q1.push_back('{due: cyc,     data: mem_m[bus1.addr]});
          q2.push_back('{due: cyc + 1, data: mem_m[bus1.addr]});
        end
      end
      exp_v1 = 1'b0;
      exp_v2 = 1'b0;
      if (q1.size() > 0 && q1[0].due == cyc) begin exp_v1 = 1'b1; exp_d1 = q1[0].data; void'(q1.pop_front()); end
      if (q2.size() > 0 && q2[0].due == cyc) begin exp_v2 = 1'b1; exp_d2 = q2[0].data; void'(q2.pop_front()); end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    check("busy1",   64'(bus1.busy),       64'(clear_left > 0));
    check("ready1",  64'(bus1.req_ready),  64'(clear_left == 0));
    check("busy2",   64'(bus2.busy),       64'(clear_left > 0));
    check("ready2",  64'(bus2.req_ready),  64'(clear_left == 0));
    check("valid1",  64'(bus1.dout_valid), 64'(exp_v1));
    check("dout1",   64'(bus1.dout),       64'(exp_d1));
    check("valid2",  64'(bus2.dout_valid), 64'(exp_v2));
    check("dout2",   64'(bus2.dout),       64'(exp_d2));
  end

  task automatic set_in(input logic v, input logic w, input logic [MW-1:0] m,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus1.req_valid = v; bus1.we = w; bus1.wmask = m; bus1.addr = a; bus1.din = d;
    bus2.req_valid = v; bus2.we = w; bus2.wmask = m; bus2.addr = a; bus2.din = d;
  endtask

  task automatic step(input logic v, input logic w, input logic [MW-1:0] m,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    set_in(v, w, m, a, d);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, '0);
  endtask

  // Counts cycles with busy high, bounded; current inputs stay applied while busy.
  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!bus1.busy) break;
      n++;
      @(posedge clk);
      #1;
    end
    set_in(1'b0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    set_in(1'b0, 1'b0, '0, '0, '0);
    rstb = 1'b1;
    #1 rstb = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_dout",  64'(bus1.dout), 64'h0);
    check("rst_valid", 64'(bus1.dout_valid), 64'h0);
    check("rst_busy",  64'(bus1.busy), 64'(CLR_EN));
    rstb = 1'b1;

`ifdef SRAM22_CLEAR_ON_RESET_EN
    // Write attempted during the sweep must be ignored.
    set_in(1'b1, 1'b1, 4'hF, 4'd3, 32'hFFFF_FFFF);
    count_busy(n);
    check("clear_cycles", 64'(n), 64'd16);
    for (int a = 0; a < int'(DEPTH); a++) begin
      step(1'b1, 1'b0, '0, AW'(a), '0);
      check("clear_rd_zero", 64'(bus1.dout), 64'h0);
    end
    step(1'b1, 1'b0, '0, 4'd3, '0);
    check("busy_write_dropped", 64'(bus1.dout), 64'h0);
`else
    for (int a = 0; a < int'(DEPTH); a++) step(1'b1, 1'b1, 4'hF, AW'(a), '0);
`endif

    step(1'b1, 1'b1, 4'hF, 4'd5, 32'hAABB_CCDD);
    step(1'b1, 1'b1, 4'h5, 4'd5, 32'h1122_3344);
    step(1'b1, 1'b0, '0,   4'd5, '0);
    check("mask_dout",  64'(bus1.dout), 64'hAA22_CC44);
    check("mask_valid", 64'(bus1.dout_valid), 64'h1);

    for (int a = 1; a <= 3; a++) step(1'b1, 1'b1, 4'hF, AW'(a), DW'(a));
    step(1'b1, 1'b0, '0, 4'd1, '0);
    check("l2_first_not_yet", 64'(bus2.dout_valid), 64'h0);
    step(1'b1, 1'b0, '0, 4'd2, '0);
    check("l2_v1", 64'(bus2.dout_valid), 64'h1);
    check("l2_d1", 64'(bus2.dout), 64'h1);
    step(1'b1, 1'b0, '0, 4'd3, '0);
    check("l2_d2", 64'(bus2.dout), 64'h2);
    idle();
    check("l2_v3", 64'(bus2.dout_valid), 64'h1);
    check("l2_d3", 64'(bus2.dout), 64'h3);
    idle();
    check("l2_end_valid", 64'(bus2.dout_valid), 64'h0);
    check("l2_hold",      64'(bus2.dout), 64'h3);

    step(1'b1, 1'b1, 4'hF, 4'd7, 32'hDEAD_BEEF);
    step(1'b1, 1'b0, '0,   4'd7, '0);
    check("raw_dout", 64'(bus1.dout), 64'hDEAD_BEEF);
    step(1'b1, 1'b1, 4'hF, 4'd8, 32'h1234_5678);
    check("wr_hold_dout",  64'(bus1.dout), 64'hDEAD_BEEF);
    check("wr_hold_valid", 64'(bus1.dout_valid), 64'h0);

    // Reset with a read in flight on both instances.
    step(1'b1, 1'b0, '0, 4'd7, '0);
    set_in(1'b0, 1'b0, '0, '0, '0);
    rstb = 1'b0;
    #1;
    check("rrd_dout1",  64'(bus1.dout), 64'h0);
    check("rrd_valid1", 64'(bus1.dout_valid), 64'h0);
    check("rrd_valid2", 64'(bus2.dout_valid), 64'h0);
    @(posedge clk);
    #1 rstb = 1'b1;

`ifdef SRAM22_CLEAR_ON_RESET_EN
    repeat (8) idle();
    rstb = 1'b0;
    #1;
    check("sweep_rst_dout",  64'(bus1.dout), 64'h0);
    check("sweep_rst_valid", 64'(bus1.dout_valid), 64'h0);
    @(posedge clk);
    #1 rstb = 1'b1;
    count_busy(n);
    check("restart_cycles", 64'(n), 64'd16);
    step(1'b1, 1'b0, '0, 4'd7, '0);
    check("post_clear_rd", 64'(bus1.dout), 64'h0);
`else
    step(1'b1, 1'b0, '0, 4'd7, '0);
    check("preserved_rd", 64'(bus1.dout), 64'hDEAD_BEEF);
`endif

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(3) != 0), 1'($urandom), MW'($urandom), AW'($urandom), DW'($urandom));
    end
    repeat (3) idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
